// File: rtl/ecc_decoder_pipe.sv
// ecc_decoder_pipe
//   Two-stage pipelined SEC-DED Hamming decoder for 8/16/32(/64)-bit codewords,
//   with the width selected per word. Valid/ready stream in and out with full
//   backpressure, plus saturating statistics and a sticky error flag.
//
//   Codeword layout for width N = 8 << mode, p = log2(N):
//     [p-1:0]   check bits
//     [p]       overall parity
//     [N-1:p+1] data bits; data bit j uses column c_j, the j-th non-power-of-two
//               integer starting at 3 (3,5,6,7,9,...)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   in_valid     input word valid
//   in_ready     decoder can accept a word this cycle (combinational from out_ready)
//   in_data      codeword; bits at index N and above are ignored
//   in_mode      00=8b 01=16b 10=32b 11=64b (64b legal only when MAX_CW=64)
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_data     decoded data, LSB-aligned, zero-extended
//   out_num_err  0=clean 1=corrected 2=uncorrectable 3=illegal mode
//   out_mode     in_mode carried with the word
//   cnt_clr      synchronous clear of counters and err_flag (wins over updates)
//   cnt_corr     saturating count of delivered corrected words
//   cnt_uncorr   saturating count of delivered uncorrectable words
//   err_flag     sticky; set on delivery of a word with out_num_err 2 or 3

module ecc_decoder_pipe #(
  parameter int MAX_CW    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_CW-1:0]    in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_CW-1:0]    out_data,
  output logic [1:0]           out_num_err,
  output logic [1:0]           out_mode,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cnt_corr,
  output logic [CNT_WIDTH-1:0] cnt_uncorr,
  output logic                 err_flag
);

  localparam int NMODES = (MAX_CW == 64) ? 4 : 3;
  localparam int SYN_W  = 6;  // wide enough for the 64-bit code

  // Handshake
  logic adv1, adv2, deliver;

  // Stage 1
  logic                 s1_valid_reg;
  logic [SYN_W-1:0]     s1_syn_reg;
  logic                 s1_par_reg;
  logic [MAX_CW-1:0]    s1_data_reg;
  logic [1:0]           s1_mode_reg;
  logic                 s1_illegal_reg;

  // Stage 2
  logic                 s2_valid_reg;
  logic [MAX_CW-1:0]    s2_data_reg;
  logic [1:0]           s2_err_reg;
  logic [1:0]           s2_mode_reg;

  // Statistics
  logic [CNT_WIDTH-1:0] cnt_corr_reg;
  logic [CNT_WIDTH-1:0] cnt_uncorr_reg;
  logic                 err_flag_reg;

  // Per-mode results flattened into packed vectors so each mode drives its own slice
  logic [NMODES*SYN_W-1:0]  syn_flat;
  logic [NMODES-1:0]        par_flat;
  logic [NMODES*MAX_CW-1:0] data_flat;
  logic [NMODES*MAX_CW-1:0] flip_flat;

  // Selected per-word values
  logic [SYN_W-1:0]  syn_sel;
  logic              par_sel;
  logic [MAX_CW-1:0] data_sel;
  logic              illegal_sel;
  logic [MAX_CW-1:0] flip_sel;
  logic [MAX_CW-1:0] dec_data;
  logic [1:0]        dec_err;

  genvar gi;
  generate
    for (gi = 0; gi < NMODES; gi++) begin : g_mode
      localparam int N = 8 << gi;
      localparam int P = 3 + gi;

      logic [SYN_W-1:0]  syn;
      logic [MAX_CW-1:0] flip;

      // Syndrome: check bits XOR the columns of every set data bit.
      always_comb begin
        int j;
        syn = SYN_W'(in_data[P-1:0]);
        j = 0;
        for (int c = 3; c < (1 << P); c++) begin
          if ((c & (c - 1)) != 0) begin
            if (in_data[P + 1 + j]) begin
              syn = syn ^ SYN_W'(c);
            end
            j++;
          end
        end
      end

      // Correction mask: the data bit whose column equals the registered syndrome.
      // Zero and power-of-two syndromes match no column, leaving data raw.
      always_comb begin
        int j;
        flip = '0;
        j = 0;
        for (int c = 3; c < (1 << P); c++) begin
          if ((c & (c - 1)) != 0) begin
            if (s1_syn_reg == SYN_W'(c)) begin
              flip[j] = 1'b1;
            end
            j++;
          end
        end
      end

      assign syn_flat[gi*SYN_W +: SYN_W]    = syn;
      assign par_flat[gi]                   = ^in_data[N-1:0];
      assign data_flat[gi*MAX_CW +: MAX_CW] = MAX_CW'(in_data[N-1:P+1]);
      assign flip_flat[gi*MAX_CW +: MAX_CW] = flip;
    end
  endgenerate

  always_comb begin
    syn_sel  = '0;
    par_sel  = 1'b0;
    data_sel = '0;
    flip_sel = '0;
    for (int m = 0; m < NMODES; m++) begin
      if (in_mode == 2'(m)) begin
        syn_sel  = syn_flat[m*SYN_W +: SYN_W];
        par_sel  = par_flat[m];
        data_sel = data_flat[m*MAX_CW +: MAX_CW];
      end
      if (s1_mode_reg == 2'(m)) begin
        flip_sel = flip_flat[m*MAX_CW +: MAX_CW];
      end
    end
  end

  assign illegal_sel = (MAX_CW != 64) && (in_mode == 2'b11);

  // Odd overall parity means a single (correctable) error; even parity with a
  // nonzero syndrome means a double error.
  always_comb begin
    dec_data = s1_data_reg;
    dec_err  = 2'd0;
    if (s1_illegal_reg) begin
      dec_data = '0;
      dec_err  = 2'd3;
    end else if (s1_par_reg) begin
      dec_data = s1_data_reg ^ flip_sel;
      dec_err  = 2'd1;
    end else if (s1_syn_reg != '0) begin
      dec_err  = 2'd2;
    end
  end

  assign adv2     = !s2_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;
  assign deliver  = s2_valid_reg && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg   <= 1'b0;
      s1_syn_reg     <= '0;
      s1_par_reg     <= 1'b0;
      s1_data_reg    <= '0;
      s1_mode_reg    <= 2'd0;
      s1_illegal_reg <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_syn_reg     <= syn_sel;
        s1_par_reg     <= par_sel;
        s1_data_reg    <= data_sel;
        s1_mode_reg    <= in_mode;
        s1_illegal_reg <= illegal_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_err_reg   <= 2'd0;
      s2_mode_reg  <= 2'd0;
    end else if (adv2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= dec_data;
        s2_err_reg  <= dec_err;
        s2_mode_reg <= s1_mode_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
      err_flag_reg   <= 1'b0;
    end else if (cnt_clr) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
      err_flag_reg   <= 1'b0;
    end else if (deliver) begin
      if (s2_err_reg == 2'd1 && cnt_corr_reg != '1) begin
        cnt_corr_reg <= cnt_corr_reg + 1'b1;
      end
      if (s2_err_reg == 2'd2 && cnt_uncorr_reg != '1) begin
        cnt_uncorr_reg <= cnt_uncorr_reg + 1'b1;
      end
      if (s2_err_reg[1]) begin
        err_flag_reg <= 1'b1;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_data    = s2_data_reg;
  assign out_num_err = s2_err_reg;
  assign out_mode    = s2_mode_reg;
  assign cnt_corr    = cnt_corr_reg;
  assign cnt_uncorr  = cnt_uncorr_reg;
  assign err_flag    = err_flag_reg;

endmodule
